// File: rtl/ccu_cmd_fetch.sv
// Command-fetch front end for the CCU: host byte FIFO, WAIT pseudo-op expansion, NOP fill.
// Optional issued-command counter is compiled in with CCU_CMD_FETCH_STATS_EN.
module ccu_cmd_fetch #(
    parameter int          DEPTH   = 8,
    parameter logic [7:0]  NOP_CMD = 8'd0,
    parameter logic [7:0]  WAIT_OP = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   host_data,
    input  logic                         host_valid,
    output logic                         host_ready,
    input  logic                         ccu_ready,
    output logic [7:0]                   cmd,
    output logic                         cmd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
`ifdef CCU_CMD_FETCH_STATS_EN
    ,
    output logic [15:0]                  issued_count
`endif
);

    // state  | meaning
    // S_RUN  | issue FIFO head, or NOP when empty
    // S_ARG  | WAIT_OP consumed, next byte is the NOP count
    // S_WAIT | counting down NOP cycles
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_ARG  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [7:0]    wait_cnt;
    logic [7:0]    head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          load_cmd;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign host_ready = (fifo_count < CW'(DEPTH));
    assign push       = host_valid && host_ready;
    assign pop        = ccu_ready && !fifo_empty && ((state == S_RUN) || (state == S_ARG));
    assign load_cmd   = pop && (state == S_RUN) && (head != WAIT_OP);
    assign busy       = !fifo_empty || (state != S_RUN);

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= 8'd0;
            cmd       <= NOP_CMD;
            cmd_valid <= 1'b0;
        end else if (ccu_ready) begin
            case (state)
                S_RUN: begin
                    if (load_cmd) begin
                        cmd       <= head;
                        cmd_valid <= 1'b1;
                    end else begin
                        cmd       <= NOP_CMD;
                        cmd_valid <= 1'b0;
                        if (pop) begin
                            state <= S_ARG;
                        end
                    end
                end
                S_ARG: begin
                    cmd       <= NOP_CMD;
                    cmd_valid <= 1'b0;
                    // An argument of WAIT_OP is just a count of 255.
                    if (pop) begin
                        if (head == 8'd0) begin
                            state <= S_RUN;
                        end else begin
                            wait_cnt <= head;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cmd       <= NOP_CMD;
                    cmd_valid <= 1'b0;
                    wait_cnt  <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd1) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    cmd       <= NOP_CMD;
                    cmd_valid <= 1'b0;
                    state     <= S_RUN;
                end
            endcase
        end
    end

`ifdef CCU_CMD_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_count <= 16'd0;
        end else if (load_cmd) begin
            issued_count <= issued_count + 16'd1;
        end
    end
`endif

endmodule
